// File: rtl/sll_shift_arbiter.sv
// sll_shift_arbiter: shares one 32-bit sll_barrel_shifter between two requesters.
// A request is granted round-robin, its operands are registered and held on the
// shifter for SETTLE_CYCLES cycles, then the result is captured and returned
// together with the requester ID. Only one operation is in flight at a time.
//
// Handshake semantics (both request and response ports): a transfer happens on a
// rising clock edge where valid and ready are both high. A producer keeps valid
// and its payload stable until that edge. Ready never depends on the response side.
module sll_shift_arbiter #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_data,
    input  logic [9:0]  req_shamt,
    output logic [31:0] sh_data_in,
    output logic [4:0]  sh_shiftamt,
    input  logic [31:0] sh_data_out,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_data,
    output logic        busy,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t      state;
    state_t      state_next;
    logic [3:0]  settle_cnt;
    logic [31:0] op_data;
    logic [4:0]  op_shamt;
    logic        op_id;
    logic        last_grant;
    logic        grant_id;
    logic        accept;
    logic        capture;

    // Round-robin choice: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant_id = 1'b0;
        case (req_valid)
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

    assign accept  = |req_ready;
    assign capture = (state == SHIFT) && (settle_cnt == 4'd1);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (settle_cnt == 4'd1) state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic; req_ready is gated by reset so it reads 0 while reset is held.
    always_comb begin
        req_ready   = 2'b00;
        sh_data_in  = 32'd0;
        sh_shiftamt = 5'd0;
        resp_valid  = 1'b0;
        busy        = 1'b0;
        fsm_state   = state;
        case (state)
            IDLE: begin
                if (reset_n) req_ready = (grant_id ? 2'b10 : 2'b01) & req_valid;
            end
            SHIFT: begin
                sh_data_in  = op_data;
                sh_shiftamt = op_shamt;
                busy        = 1'b1;
            end
            RESP: begin
                resp_valid = 1'b1;
                busy       = 1'b1;
            end
            default: begin
                req_ready = 2'b00;
            end
        endcase
    end

    // Operand capture on accept and settle countdown while the shifter settles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_data    <= 32'd0;
            op_shamt   <= 5'd0;
            op_id      <= 1'b0;
            last_grant <= 1'b1;
            settle_cnt <= 4'd0;
        end else if (accept) begin
            op_data    <= grant_id ? req_data[63:32] : req_data[31:0];
            op_shamt   <= grant_id ? req_shamt[9:5] : req_shamt[4:0];
            op_id      <= grant_id;
            last_grant <= grant_id;
            settle_cnt <= SETTLE_LOAD;
        end else if (state == SHIFT) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    // Response registers: loaded once at the end of the settle window, then held.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_data <= 32'd0;
            resp_id   <= 1'b0;
        end else if (capture) begin
            resp_data <= sh_data_out;
            resp_id   <= op_id;
        end
    end

endmodule

// File: tb/tb_sll_shift_arbiter.sv
// tb_sll_shift_arbiter: two arbiter instances (settle 1 and settle 3), each
// driving a behavioural left shifter, checked against a transaction-level model.
module tb_sll_shift_arbiter;

    localparam int N = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid   [N];
    logic [1:0]  req_ready   [N];
    logic [63:0] req_data    [N];
    logic [9:0]  req_shamt   [N];
    logic [31:0] sh_data_in  [N];
    logic [4:0]  sh_shiftamt [N];
    logic [31:0] sh_data_out [N];
    logic        resp_valid  [N];
    logic        resp_ready  [N];
    logic        resp_id     [N];
    logic [31:0] resp_data   [N];
    logic        busy        [N];
    logic [1:0]  fsm_state   [N];

    int n_tests = 0;
    int n_fail  = 0;

    // model: who was served last per instance, and expected {id, data} responses
    bit          m_last [N];
    logic [32:0] exp_q[$];

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            sll_shift_arbiter #(.SETTLE_CYCLES(g == 0 ? 1 : 3)) u_dut (
                .clock       (clock),
                .reset_n     (reset_n),
                .req_valid   (req_valid[g]),
                .req_ready   (req_ready[g]),
                .req_data    (req_data[g]),
                .req_shamt   (req_shamt[g]),
                .sh_data_in  (sh_data_in[g]),
                .sh_shiftamt (sh_shiftamt[g]),
                .sh_data_out (sh_data_out[g]),
                .resp_valid  (resp_valid[g]),
                .resp_ready  (resp_ready[g]),
                .resp_id     (resp_id[g]),
                .resp_data   (resp_data[g]),
                .busy        (busy[g]),
                .fsm_state   (fsm_state[g])
            );
            assign sh_data_out[g] = sh_data_in[g] << sh_shiftamt[g];
        end
    endgenerate

    // clock
    always #5 clock = ~clock;

    function automatic int settle(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input int d);
        check_eq("rst_req_ready", req_ready[d], 0);
        check_eq("rst_resp_valid", resp_valid[d], 0);
        check_eq("rst_resp_id", resp_id[d], 0);
        check_eq("rst_resp_data", resp_data[d], 0);
        check_eq("rst_sh_data_in", sh_data_in[d], 0);
        check_eq("rst_sh_shiftamt", sh_shiftamt[d], 0);
        check_eq("rst_busy", busy[d], 0);
    endtask

    // reset held across edges; released just after a rising edge so the next
    // rising edge is the first one with reset high
    task automatic do_reset();
        reset_n = 1'b0;
        for (int d = 0; d < N; d++) begin
            req_valid[d]  = 2'b00;
            req_data[d]   = 64'd0;
            req_shamt[d]  = 10'd0;
            resp_ready[d] = 1'b1;
            m_last[d]     = 1'b1;
        end
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        for (int d = 0; d < N; d++) check_reset_vals(d);
        #1;
        reset_n = 1'b1;
    endtask

    // one full transaction: present requests, check grant, settle window,
    // response (with optional backpressure); returns during the handshake cycle
    task automatic run_op(input int d, input logic [1:0] mask,
                          input logic [31:0] d0, input logic [4:0] s0,
                          input logic [31:0] d1, input logic [4:0] s1,
                          input int stall);
        bit          g;
        logic [31:0] opd;
        logic [4:0]  ops;
        logic [32:0] exp;
        @(negedge clock);
        req_valid[d]  = mask;
        req_data[d]   = {d1, d0};
        req_shamt[d]  = {s1, s0};
        resp_ready[d] = (stall == 0);
        #1;
        if (mask == 2'b11) g = ~m_last[d];
        else               g = (mask == 2'b10);
        check_eq("idle_busy", busy[d], 0);
        check_eq("idle_resp_valid", resp_valid[d], 0);
        check_eq("grant", req_ready[d], g ? 2'b10 : 2'b01);
        @(posedge clock);
        m_last[d] = g;
        opd = g ? d1 : d0;
        ops = g ? s1 : s0;
        exp_q.push_back({g, opd << ops});
        for (int c = 0; c < settle(d); c++) begin
            @(negedge clock);
            #1;
            check_eq("shift_busy", busy[d], 1);
            check_eq("shift_req_ready", req_ready[d], 0);
            check_eq("shift_resp_valid", resp_valid[d], 0);
            check_eq("shift_data_in", sh_data_in[d], opd);
            check_eq("shift_amt", sh_shiftamt[d], ops);
        end
        @(negedge clock);
        #1;
        exp = exp_q.pop_front();
        check_eq("resp_valid", resp_valid[d], 1);
        check_eq("resp_id", resp_id[d], exp[32]);
        check_eq("resp_data", resp_data[d], exp[31:0]);
        check_eq("resp_req_ready", req_ready[d], 0);
        check_eq("resp_sh_data_in", sh_data_in[d], 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            #1;
            check_eq("stall_resp_valid", resp_valid[d], 1);
            check_eq("stall_resp_id", resp_id[d], exp[32]);
            check_eq("stall_resp_data", resp_data[d], exp[31:0]);
            check_eq("stall_req_ready", req_ready[d], 0);
        end
        resp_ready[d] = 1'b1;
    endtask

    task automatic idle_check(input int d);
        @(negedge clock);
        req_valid[d] = 2'b00;
        #1;
        check_eq("idle_after_busy", busy[d], 0);
        check_eq("idle_after_resp_valid", resp_valid[d], 0);
        check_eq("idle_after_req_ready", req_ready[d], 0);
    endtask

    // start an op from requester 0, then pulse reset in SHIFT (in_resp=0) or RESP
    task automatic reset_mid(input int d, input bit in_resp);
        @(negedge clock);
        req_valid[d] = 2'b01;
        req_data[d]  = {32'h0, $urandom()};
        req_shamt[d] = {5'd0, 5'($urandom_range(0, 31))};
        @(posedge clock);
        @(negedge clock);
        req_valid[d] = 2'b00;
        if (in_resp) repeat (settle(d)) @(negedge clock);
        #1;
        check_eq(in_resp ? "pre_rst_resp_valid" : "pre_rst_busy",
                 in_resp ? resp_valid[d] : busy[d], 1);
        #1;
        req_valid[d] = 2'b11;
        reset_n = 1'b0;
        #1;
        check_reset_vals(d);
        @(posedge clock);
        #1;
        check_reset_vals(d);
        req_valid[d] = 2'b00;
        m_last[0] = 1'b1;
        m_last[1] = 1'b1;
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        check_eq("post_rst_resp_valid", resp_valid[d], 0);
        check_eq("post_rst_busy", busy[d], 0);
    endtask

    initial begin
        do_reset();

        // single request
        run_op(0, 2'b01, 32'h0000_04D2, 5'd3, 32'h0, 5'd0, 0);
        idle_check(0);

        // simultaneous requests from reset, fairness
        do_reset();
        for (int i = 0; i < 4; i++)
            run_op(0, 2'b11, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001, 5'd31, 0);

        // backpressure with the other requester waiting
        run_op(0, 2'b11, $urandom(), 5'($urandom_range(0, 31)),
               $urandom(), 5'($urandom_range(0, 31)), 5);

        // shift amount sweep
        for (int s = 0; s < 32; s++)
            run_op(0, (s % 2 == 1) ? 2'b10 : 2'b01,
                   32'hFFFF_FFFF, 5'(s), 32'hFFFF_FFFF, 5'(s), 0);
        idle_check(0);

        // requester raises then drops valid before any edge: nothing happens
        @(negedge clock);
        req_valid[0] = 2'b10;
        #1;
        check_eq("drop_req_ready", req_ready[0], 2'b10);
        #2;
        req_valid[0] = 2'b00;
        @(negedge clock);
        #1;
        check_eq("drop_busy", busy[0], 0);
        run_op(0, 2'b11, $urandom(), 5'($urandom_range(0, 31)),
               $urandom(), 5'($urandom_range(0, 31)), 0);

        // random traffic, settle 1
        for (int i = 0; i < 40; i++)
            run_op(0, 2'($urandom_range(1, 3)), $urandom(), 5'($urandom_range(0, 31)),
                   $urandom(), 5'($urandom_range(0, 31)), $urandom_range(0, 3));
        idle_check(0);

        // random traffic, settle 3
        for (int i = 0; i < 30; i++)
            run_op(1, 2'($urandom_range(1, 3)), $urandom(), 5'($urandom_range(0, 31)),
                   $urandom(), 5'($urandom_range(0, 31)), $urandom_range(0, 3));
        run_op(1, 2'b11, $urandom(), 5'($urandom_range(0, 31)),
               $urandom(), 5'($urandom_range(0, 31)), 5);
        idle_check(1);

        // reset during SHIFT, then during RESP; tie afterwards goes to requester 0
        reset_mid(1, 1'b0);
        reset_mid(1, 1'b1);
        run_op(1, 2'b11, 32'h1234_5678, 5'd8, 32'h8765_4321, 5'd1, 0);
        run_op(1, 2'b11, 32'h1234_5678, 5'd8, 32'h8765_4321, 5'd1, 0);
        idle_check(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sll_shift_arbiter.md
# sll_shift_arbiter

Sequencer and two-way round-robin arbiter that shares one 32-bit `sll_barrel_shifter` between two requesters in the ALU. It accepts a shift request over a valid/ready handshake and drives the shifter from registered operands. It waits a programmable settle time, captures the result, and returns it with the requester ID over a second valid/ready handshake. One operation is in flight at a time.

## Interface
- `SETTLE_CYCLES`, default 1: cycles the shifter inputs are held stable before the result is captured; legal range 1–15.
- `clock` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `req_valid` input 2: bit i means requester i has a request.
- `req_ready` output 2: bit i means requester i's request is accepted this cycle; at most one bit set.
- `req_data` input 64: requester i's operand in bits [32i+31:32i].
- `req_shamt` input 10: requester i's shift amount in bits [5i+4:5i].
- `sh_data_in` output 32: to shifter `data_in`.
- `sh_shiftamt` output 5: to shifter `ctrl_shiftamt`.
- `sh_data_out` input 32: from shifter `data_out`.
- `resp_valid` output 1: result available.
- `resp_ready` input 1: consumer accepts the result.
- `resp_id` output 1: requester that issued the result.
- `resp_data` output 32: shifted result.
- `busy` output 1: high in SHIFT or RESP.

## Operation
- FSM states: IDLE, SHIFT, RESP. Reset state is IDLE.
- **IDLE**
  - `req_ready` is combinational: the granted bit is set only if that requester's `req_valid` is high.
  - If exactly one `req_valid` bit is high, that requester is granted.
  - If both are high, the grant goes to the requester ≠ `last_grant`.
- **Accept** (`req_valid[i] & req_ready[i]` at a clock edge):
  - Latch operand, shamt and i into `op_data`, `op_shamt`, `op_id`.
  - Set `last_grant` = i and load the settle counter with `SETTLE_CYCLES`.
  - Next state is SHIFT.
- **SHIFT**
  - The counter decrements each cycle.
  - On the edge where the counter equals 1: `resp_data` ← `sh_data_out`, `resp_id` ← `op_id`, next state is RESP.
- **RESP**
  - `resp_valid` = 1. `resp_data` and `resp_id` are held stable until `resp_ready` is high.
  - On `resp_valid & resp_ready`: next state is IDLE.
- `req_ready` = 0 in SHIFT and RESP. Requests arriving then wait; no request is dropped or queued internally.
- `sh_data_in` = `op_data` and `sh_shiftamt` = `op_shamt` in SHIFT; both are 0 otherwise.
- The arbiter does not compute the shift. `resp_data` is exactly what the shifter returns: `op_data << op_shamt`, zero-filled, truncated to 32 bits.
- A requester that drops `req_valid` before acceptance is simply not granted. No state changes.

## Timing
- **Reset values:** `req_ready` = 0, `resp_valid` = 0, `resp_id` = 0, `resp_data` = 0, `sh_data_in` = 0, `sh_shiftamt` = 0, `busy` = 0, `last_grant` = 1 (requester 0 wins the first tie).
- **Latency:** accept at edge k → result captured at edge k+`SETTLE_CYCLES` → `resp_valid` high from that edge.
- **Minimum accept-to-accept spacing:** `SETTLE_CYCLES`+2 edges, with `resp_ready` tied high.
- **`resp_ready` low:** RESP holds indefinitely. The response holds no combinational path to `req_ready`.
- **Reset during SHIFT or RESP:** `reset_n` low asynchronously forces all outputs to their reset values and the FSM to IDLE. The in-flight operation is discarded with no response.
- **Reset release:** the first accept may occur on the first rising edge with `reset_n` high.
- **Fairness:** with both requesters held valid continuously, grants alternate 0, 1, 0, 1, ….

## Test plan
- **Single request:** requester 0, data 0x0000_04D2, shamt 3, `SETTLE_CYCLES`=1 → `resp_valid` one edge after accept, `resp_id`=0, `resp_data`=0x0000_2690.
- **Simultaneous requests:** both valid from reset; r0 0xFFFF_FFFF shamt 4, r1 0x0000_0001 shamt 31 → r0 is served first with 0xFFFF_FFF0, then r1 with 0x8000_0000. Both held valid for 4 ops → ids 0, 1, 0, 1.
- **Backpressure:** `resp_ready` low for 5 cycles after `resp_valid` → `resp_data` and `resp_id` are stable and `req_ready` = 0 throughout. The response is consumed on the cycle `resp_ready` rises, and IDLE is re-entered on the next edge.
- **Shift amount sweep:** shamt 0–31 on 0xFFFF_FFFF → each result equals 0xFFFF_FFFF << shamt. Shamt 0 returns 0xFFFF_FFFF.
- **Settle parameter:** `SETTLE_CYCLES`=3 → `sh_data_in` and `sh_shiftamt` are stable for 3 cycles, and `resp_valid` asserts exactly 3 edges after accept.
- **Reset mid-operation:** `reset_n` pulsed low during SHIFT, then again during RESP → outputs go to 0 immediately and no response appears. The next request is served normally, with requester 0 winning a tie.
